// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - M-mode trap sequencer: flush handshake, trap CSR commit, fetch redirect
// Optional feature: define TRAP_VECTORED_EN for vectored interrupt dispatch (mtvec.MODE==1).
module trap_ctrl #(
  parameter logic [1:0]  RESET_PRIV = 2'b11,
  parameter int unsigned FLUSH_TMO  = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_exc_req,
  input  logic [31:0] i_exc_cause,
  input  logic [31:0] i_exc_tval,
  input  logic [31:0] i_exc_pc,
  input  logic        i_irq_req,
  input  logic [31:0] i_irq_cause,
  input  logic [31:0] i_irq_pc,
  input  logic        i_mret,
  input  logic [31:0] i_mtvec,
  input  logic        i_flush_ack,
  output logic        o_flush_req,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic [1:0]  o_priv_mode,
  output logic [31:0] o_mepc,
  output logic [31:0] o_mcause,
  output logic [31:0] o_mtval,
  output logic        o_mie,
  output logic        o_mpie,
  output logic [1:0]  o_mpp,
  output logic        o_trap_busy
);

  localparam logic [1:0]  PRIV_U       = 2'b00;
  localparam logic [1:0]  PRIV_M       = 2'b11;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;

  // Counter only needs to reach FLUSH_TMO-1; the final FLUSH cycle forces COMMIT.
  localparam int unsigned CW       = (FLUSH_TMO > 1) ? $clog2(FLUSH_TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(FLUSH_TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Latched event: kind (MRET or trap, interrupt or exception) and its payload.
  logic          is_mret_q, is_mret_d;
  logic          is_irq_q, is_irq_d;
  logic [31:0]   cause_q, cause_d;
  logic [31:0]   tval_q, tval_d;
  logic [31:0]   pc_q, pc_d;

  // Architectural state owned by this block.
  logic [1:0]    priv_q, priv_d;
  logic [31:0]   mepc_q, mepc_d;
  logic [31:0]   mcause_q, mcause_d;
  logic [31:0]   mtval_q, mtval_d;
  logic          mie_q, mie_d;
  logic          mpie_q, mpie_d;
  logic [1:0]    mpp_q, mpp_d;

  logic [31:0]   trap_target;
  logic          take_irq;

  // Trap vector: BASE always; BASE + 4*cause for interrupts in vectored mode when enabled.
  always_comb begin
    trap_target = {i_mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (is_irq_q && (i_mtvec[1:0] == 2'b01)) begin
      trap_target = {i_mtvec[31:2], 2'b00} + {cause_q[29:0], 2'b00};
    end
`endif
  end

`ifndef TRAP_VECTORED_EN
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^i_mtvec[1:0];
`endif

  // Interrupts in U-mode are always taken; in M-mode only with mstatus.MIE set.
  assign take_irq = i_irq_req && (mie_q || (priv_q == PRIV_U));

  // State, event latch and CSR registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_mret_q <= 1'b0;
      is_irq_q  <= 1'b0;
      cause_q   <= '0;
      tval_q    <= '0;
      pc_q      <= '0;
      priv_q    <= RESET_PRIV;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      mpp_q     <= PRIV_M;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_mret_q <= is_mret_d;
      is_irq_q  <= is_irq_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      pc_q      <= pc_d;
      priv_q    <= priv_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mtval_q   <= mtval_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      mpp_q     <= mpp_d;
    end
  end

  // Next-state, event capture, CSR commit and output strobes.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    is_mret_d        = is_mret_q;
    is_irq_d         = is_irq_q;
    cause_d          = cause_q;
    tval_d           = tval_q;
    pc_d             = pc_q;
    priv_d           = priv_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mpp_d            = mpp_q;
    o_flush_req      = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;

    case (state_q)
      S_IDLE: begin
        if (i_exc_req) begin
          // Exception beats a simultaneous interrupt or MRET.
          state_d   = S_FLUSH;
          is_mret_d = 1'b0;
          is_irq_d  = 1'b0;
          cause_d   = i_exc_cause;
          tval_d    = i_exc_tval;
          pc_d      = i_exc_pc;
        end else if (take_irq) begin
          state_d   = S_FLUSH;
          is_mret_d = 1'b0;
          is_irq_d  = 1'b1;
          cause_d   = i_irq_cause;
          tval_d    = '0;
          pc_d      = i_irq_pc;
        end else if (i_mret) begin
          state_d  = S_FLUSH;
          is_irq_d = 1'b0;
          if (priv_q == PRIV_M) begin
            is_mret_d = 1'b1;
          end else begin
            // Should have been filtered upstream; fall back to illegal-instruction
            // trap at the retiring PC presented on i_exc_pc.
            is_mret_d = 1'b0;
            cause_d   = CAUSE_ILLEGAL;
            tval_d    = '0;
            pc_d      = i_exc_pc;
          end
        end
        if (state_d == S_FLUSH) begin
          cnt_d = '0;
        end
      end

      S_FLUSH: begin
        o_flush_req = 1'b1;
        if (i_flush_ack) begin
          state_d = S_COMMIT;
        end else if ((FLUSH_TMO != 0) && (cnt_q == TMO_LAST)) begin
          state_d = S_COMMIT;
        end else if (FLUSH_TMO != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_COMMIT: begin
        o_redirect_valid = 1'b1;
        state_d          = S_IDLE;
        if (is_mret_q) begin
          o_redirect_pc = mepc_q;
          priv_d        = mpp_q;
          mie_d         = mpie_q;
          mpie_d        = 1'b1;
          mpp_d         = PRIV_U;
        end else begin
          o_redirect_pc = trap_target;
          mepc_d        = {pc_q[31:2], 2'b00};
          mcause_d      = cause_q;
          mtval_d       = tval_q;
          mpie_d        = mie_q;
          mie_d         = 1'b0;
          mpp_d         = priv_q;
          priv_d        = PRIV_M;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_trap_busy = (state_q != S_IDLE);
  assign o_priv_mode = priv_q;
  assign o_mepc      = mepc_q;
  assign o_mcause    = mcause_q;
  assign o_mtval     = mtval_q;
  assign o_mie       = mie_q;
  assign o_mpie      = mpie_q;
  assign o_mpp       = mpp_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl: directed table, corner sequences, random vs model
module tb_trap_ctrl;

  localparam int TMO = 64;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_exc_req, i_irq_req, i_mret, i_flush_ack;
  logic [31:0] i_exc_cause, i_exc_tval, i_exc_pc, i_irq_cause, i_irq_pc, i_mtvec;
  logic        o_flush_req, o_redirect_valid, o_mie, o_mpie, o_trap_busy;
  logic [31:0] o_redirect_pc, o_mepc, o_mcause, o_mtval;
  logic [1:0]  o_priv_mode, o_mpp;

  int errors = 0;
  int checks = 0;

  trap_ctrl #(.RESET_PRIV(2'b11), .FLUSH_TMO(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_exc_req(i_exc_req), .i_exc_cause(i_exc_cause), .i_exc_tval(i_exc_tval), .i_exc_pc(i_exc_pc),
    .i_irq_req(i_irq_req), .i_irq_cause(i_irq_cause), .i_irq_pc(i_irq_pc),
    .i_mret(i_mret), .i_mtvec(i_mtvec), .i_flush_ack(i_flush_ack),
    .o_flush_req(o_flush_req), .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_priv_mode(o_priv_mode), .o_mepc(o_mepc), .o_mcause(o_mcause), .o_mtval(o_mtval),
    .o_mie(o_mie), .o_mpie(o_mpie), .o_mpp(o_mpp), .o_trap_busy(o_trap_busy)
  );

  always #5 i_clk = ~i_clk;

  // Event kinds: 0 idle, 1 exception, 2 interrupt, 3 MRET, 4 exception+MRET, 5 exception+interrupt
  typedef struct {
    int          kind;
    logic [31:0] cause, tval, pc, mtvec;
    int          delay;
    bit          noise;
    bit          trap;
    logic [31:0] exp_pc, exp_pc_vec, mepc, mcause, mtval;
    logic [1:0]  priv;
    bit          mie, mpie;
    logic [1:0]  mpp;
  } vec_t;

  vec_t tbl[13];

  // Architectural reference state.
  logic [1:0]  m_priv, m_mpp;
  logic        m_mie, m_mpie;
  logic [31:0] m_mepc, m_mcause, m_mtval;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_csrs(input string tag, input logic [31:0] mepc, mcause, mtval,
                          input logic [1:0] priv, input bit mie, mpie, input logic [1:0] mpp);
    chk({tag, ".mepc"},   o_mepc,   mepc);
    chk({tag, ".mcause"}, o_mcause, mcause);
    chk({tag, ".mtval"},  o_mtval,  mtval);
    chk({tag, ".priv"},   {30'd0, o_priv_mode}, {30'd0, priv});
    chk({tag, ".mie"},    {31'd0, o_mie},  {31'd0, mie});
    chk({tag, ".mpie"},   {31'd0, o_mpie}, {31'd0, mpie});
    chk({tag, ".mpp"},    {30'd0, o_mpp},  {30'd0, mpp});
  endtask

  task automatic clear_inputs();
    i_exc_req = 0; i_irq_req = 0; i_mret = 0;
    i_exc_cause = 0; i_exc_tval = 0; i_exc_pc = 0; i_irq_cause = 0; i_irq_pc = 0;
  endtask

  function automatic vec_t mk(int kind, logic [31:0] cause, tval, pc, mtvec, int delay, bit noise,
                              bit trap, logic [31:0] exp_pc, exp_pc_vec, mepc, mcause, mtval,
                              logic [1:0] priv, bit mie, mpie, logic [1:0] mpp);
    vec_t v;
    v.kind = kind; v.cause = cause; v.tval = tval; v.pc = pc; v.mtvec = mtvec;
    v.delay = delay; v.noise = noise; v.trap = trap; v.exp_pc = exp_pc; v.exp_pc_vec = exp_pc_vec;
    v.mepc = mepc; v.mcause = mcause; v.mtval = mtval; v.priv = priv;
    v.mie = mie; v.mpie = mpie; v.mpp = mpp;
    return v;
  endfunction

  // Present one event, then run the flush handshake acking after `delay` FLUSH cycles.
  task automatic do_event(input string tag, input int kind, input logic [31:0] cause, tval, pc, mtvec,
                          input int delay, input bit noise, input bit exp_trap, input logic [31:0] exp_pc);
    int idx;
    int bad;
    bit seen;
    int exp_lat;
    @(negedge i_clk);
    i_mtvec = mtvec;
    case (kind)
      1: begin i_exc_req = 1; i_exc_cause = cause; i_exc_tval = tval; i_exc_pc = pc; end
      2: begin i_irq_req = 1; i_irq_cause = cause; i_irq_pc = pc; i_exc_pc = ~pc; end
      3: begin i_mret = 1; i_exc_pc = pc; end
      4: begin i_exc_req = 1; i_exc_cause = cause; i_exc_tval = tval; i_exc_pc = pc; i_mret = 1; end
      5: begin
        i_exc_req = 1; i_exc_cause = cause; i_exc_tval = tval; i_exc_pc = pc;
        i_irq_req = 1; i_irq_cause = 32'h8000000B; i_irq_pc = pc ^ 32'h100;
      end
      default: ;
    endcase
    @(negedge i_clk);
    clear_inputs();
    if (!exp_trap) begin
      chk({tag, ".idle_busy"},  {31'd0, o_trap_busy}, 32'd0);
      chk({tag, ".idle_flush"}, {31'd0, o_flush_req}, 32'd0);
      @(negedge i_clk);
      chk({tag, ".idle_busy2"}, {31'd0, o_trap_busy}, 32'd0);
      return;
    end
    idx = 1; bad = 0; seen = 0;
    while (idx <= 200) begin
      if (o_redirect_valid) begin
        seen = 1;
        break;
      end
      if (o_flush_req !== 1'b1 || o_trap_busy !== 1'b1) bad++;
      i_flush_ack = (idx >= delay + 1);
      if (noise) begin
        i_exc_req = 1'($urandom_range(0, 1)); i_irq_req = 1'($urandom_range(0, 1));
        i_mret = 1'($urandom_range(0, 1)); i_exc_cause = $urandom; i_irq_cause = $urandom | 32'h80000000;
        i_exc_pc = $urandom; i_irq_pc = $urandom; i_exc_tval = $urandom;
      end
      @(negedge i_clk);
      idx++;
    end
    i_flush_ack = 0;
    clear_inputs();
    if (!seen) begin
      chk({tag, ".redirect_timeout"}, 32'd0, 32'd1);
      return;
    end
    exp_lat = 1 + (((delay + 1) < TMO) ? (delay + 1) : TMO);
    chk({tag, ".flush_held"},  bad, 32'd0);
    chk({tag, ".latency"},     idx, exp_lat);
    chk({tag, ".redirect_pc"}, o_redirect_pc, exp_pc);
    chk({tag, ".flush_drop"},  {31'd0, o_flush_req}, 32'd0);
    @(negedge i_clk);
    chk({tag, ".strobe_1cyc"}, {31'd0, o_redirect_valid}, 32'd0);
    chk({tag, ".busy_clear"},  {31'd0, o_trap_busy}, 32'd0);
  endtask

  function automatic logic [31:0] m_target(bit irq, logic [31:0] cause, logic [31:0] mtvec);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
    if (irq && (mtvec % 4) == 1) return base + 4 * (cause & 32'h7FFF_FFFF);
`endif
    return base;
  endfunction

  task automatic m_reset();
    m_priv = 2'b11; m_mpp = 2'b11; m_mie = 0; m_mpie = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endtask

  task automatic m_trap(input logic [31:0] cause, tval, pc);
    m_mepc = pc & ~32'd3; m_mcause = cause; m_mtval = tval;
    m_mpie = m_mie; m_mie = 0; m_mpp = m_priv; m_priv = 2'b11;
  endtask

  task automatic m_mret();
    m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 2'b00;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".busy"},     {31'd0, o_trap_busy}, 32'd0);
    chk({tag, ".flush"},    {31'd0, o_flush_req}, 32'd0);
    chk({tag, ".redir_v"},  {31'd0, o_redirect_valid}, 32'd0);
    chk({tag, ".redir_pc"}, o_redirect_pc, 32'd0);
    chk_csrs(tag, 32'd0, 32'd0, 32'd0, 2'b11, 0, 0, 2'b11);
  endtask

  initial begin
    logic [31:0] tgt, cause, tval, pc, mtvec;
    int kind, delay;
    bit trap;

    i_rst_n = 0; i_flush_ack = 0; i_mtvec = 0;
    clear_inputs();
    repeat (3) @(negedge i_clk);
    chk_reset_values("reset");
    i_rst_n = 1;

    tbl[0]  = mk(1, 32'd2, 32'h13, 32'h80000104, 32'h80000000, 0, 0, 1, 32'h80000000, 32'h80000000,
                 32'h80000104, 32'd2, 32'h13, 2'b11, 0, 0, 2'b11);
    tbl[1]  = mk(3, 0, 0, 0, 32'h80000000, 2, 0, 1, 32'h80000104, 32'h80000104,
                 32'h80000104, 32'd2, 32'h13, 2'b11, 0, 1, 2'b00);
    tbl[2]  = mk(3, 0, 0, 0, 32'h80000000, 1, 0, 1, 32'h80000104, 32'h80000104,
                 32'h80000104, 32'd2, 32'h13, 2'b00, 1, 1, 2'b00);
    tbl[3]  = mk(1, 32'd8, 0, 32'h00001002, 32'h80000100, 3, 1, 1, 32'h80000100, 32'h80000100,
                 32'h00001000, 32'd8, 0, 2'b11, 0, 1, 2'b00);
    tbl[4]  = mk(3, 0, 0, 0, 32'h80000100, 0, 0, 1, 32'h00001000, 32'h00001000,
                 32'h00001000, 32'd8, 0, 2'b00, 1, 1, 2'b00);
    tbl[5]  = mk(2, 32'h80000007, 32'hDEAD, 32'h2004, 32'h80000001, 0, 0, 1, 32'h80000000, 32'h8000001C,
                 32'h2004, 32'h80000007, 0, 2'b11, 0, 1, 2'b00);
    tbl[6]  = mk(4, 32'd5, 32'h44, 32'h80000200, 32'h80000000, 1, 1, 1, 32'h80000000, 32'h80000000,
                 32'h80000200, 32'd5, 32'h44, 2'b11, 0, 0, 2'b11);
    tbl[7]  = mk(2, 32'h80000003, 0, 32'h5000, 32'h80000000, 0, 0, 0, 0, 0,
                 32'h80000200, 32'd5, 32'h44, 2'b11, 0, 0, 2'b11);
    tbl[8]  = mk(3, 0, 0, 0, 32'h80000000, 0, 0, 1, 32'h80000200, 32'h80000200,
                 32'h80000200, 32'd5, 32'h44, 2'b11, 0, 1, 2'b00);
    tbl[9]  = mk(3, 0, 0, 0, 32'h80000000, 4, 0, 1, 32'h80000200, 32'h80000200,
                 32'h80000200, 32'd5, 32'h44, 2'b00, 1, 1, 2'b00);
    tbl[10] = mk(3, 0, 0, 32'h3008, 32'h80000401, 0, 0, 1, 32'h80000400, 32'h80000400,
                 32'h3008, 32'd2, 0, 2'b11, 0, 1, 2'b00);
    tbl[11] = mk(1, 32'd3, 32'h80000410, 32'h80000412, 32'h80000400, 70, 0, 1, 32'h80000400, 32'h80000400,
                 32'h80000410, 32'd3, 32'h80000410, 2'b11, 0, 0, 2'b11);
    tbl[12] = mk(2, 32'h80000007, 0, 32'h6000, 32'h80000001, 0, 0, 0, 0, 0,
                 32'h80000410, 32'd3, 32'h80000410, 2'b11, 0, 0, 2'b11);

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
`ifdef TRAP_VECTORED_EN
      tgt = tbl[i].exp_pc_vec;
`else
      tgt = tbl[i].exp_pc;
`endif
      do_event(tag, tbl[i].kind, tbl[i].cause, tbl[i].tval, tbl[i].pc, tbl[i].mtvec,
               tbl[i].delay, tbl[i].noise, tbl[i].trap, tgt);
      chk_csrs(tag, tbl[i].mepc, tbl[i].mcause, tbl[i].mtval, tbl[i].priv,
               tbl[i].mie, tbl[i].mpie, tbl[i].mpp);
    end

    // Reset while FLUSH is pending: abort without commit, CSRs back to reset values.
    @(negedge i_clk);
    i_exc_req = 1; i_exc_cause = 32'd7; i_exc_tval = 32'h55; i_exc_pc = 32'h1234; i_mtvec = 32'h100;
    @(negedge i_clk);
    clear_inputs();
    chk("rst_mid.flush_before", {31'd0, o_flush_req}, 32'd1);
    #2 i_rst_n = 0;
    #1 chk_reset_values("rst_mid");
    @(negedge i_clk);
    i_rst_n = 1; i_flush_ack = 1;
    repeat (2) @(negedge i_clk);
    i_flush_ack = 0;
    chk("rst_mid.no_commit_busy", {31'd0, o_trap_busy}, 32'd0);
    chk("rst_mid.no_commit_mcause", o_mcause, 32'd0);
    m_reset();

    for (int n = 0; n < 60; n++) begin
      string tag;
      tag = $sformatf("rnd%0d", n);
      kind  = $urandom_range(1, 5);
      cause = $urandom_range(0, 15);
      tval  = $urandom;
      pc    = $urandom;
      mtvec = $urandom;
      delay = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 80) : $urandom_range(0, 4);
      if (kind == 2) cause = 32'h80000000 | $urandom_range(0, 31);
      trap = 1;
      tgt  = 0;
      case (kind)
        2: begin
          if (m_mie || m_priv == 2'b00) begin
            tgt = m_target(1, cause, mtvec);
            m_trap(cause, 0, pc);
          end else begin
            trap = 0;
          end
        end
        3: begin
          if (m_priv == 2'b11) begin
            tgt = m_mepc;
            m_mret();
          end else begin
            tgt = m_target(0, 32'd2, mtvec);
            m_trap(32'd2, 0, pc);
          end
        end
        default: begin
          tgt = m_target(0, cause, mtvec);
          m_trap(cause, tval, pc);
        end
      endcase
      do_event(tag, kind, cause, tval, pc, mtvec, delay, n[0], trap, tgt);
      chk_csrs(tag, m_mepc, m_mcause, m_mtval, m_priv, m_mie, m_mpie, m_mpp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
